// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the line-granular backing memory.
//   state_e : transaction FSM states
//   port_e  : which cache port owns the current transaction
//   calc_*  : derive line byte count, offset width and index width from parameters
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRespond,
        StCooldown
    } state_e;

    typedef enum logic {
        PortI,
        PortD
    } port_e;

    function automatic int unsigned calc_line_bytes(input int unsigned line_size);
        return line_size / 8;
    endfunction

    function automatic int unsigned calc_off_bits(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned calc_idx_bits(input int unsigned mem_lines);
        return $clog2(mem_lines);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line storage: DEPTH x LINE_W, one synchronous read/write port.
//   clk     : clock
//   we_i    : write wdata_i into line idx_i on this edge
//   idx_i   : line index for both read and write
//   wdata_i : line to write
//   rdata_o : registered read of line idx_i (old contents on a same-edge write)
// Contents have no reset and survive the block reset.
module mem_line_array #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Backing memory serving instruction-cache refills and data-cache refills/write-backs,
// one transaction at a time, with a fixed MEM_LATENCY from acceptance to ready.
//   clk, reset        : clock, synchronous active-high reset
//   in_i_read_en/addr : instruction line read request
//   out_i_read_data   : line returned to the instruction cache (held between reads)
//   out_i_ready       : one-cycle completion pulse, instruction port
//   in_d_read_en/write_en/addr/write_data : data-cache refill or write-back request
//   out_d_read_data   : line returned to the data cache (held across writes)
//   out_d_ready       : one-cycle completion pulse, data port
// The data port wins when both ports request in the same cycle.
module main_memory
    import mem_pkg::*;
#(
    parameter int unsigned CACHE_LINE_SIZE = 128,
    parameter int unsigned MEM_LINES       = 1024,
    parameter int unsigned MEM_LATENCY     = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_i_read_en,
    input  logic [31:0]                in_i_addr,
    output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
    output logic                       out_i_ready,
    input  logic                       in_d_read_en,
    input  logic                       in_d_write_en,
    input  logic [31:0]                in_d_addr,
    input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
    output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
    output logic                       out_d_ready
);

    localparam int unsigned LINE_BYTES = calc_line_bytes(CACHE_LINE_SIZE);
    localparam int unsigned OFF_BITS   = calc_off_bits(LINE_BYTES);
    localparam int unsigned IDX_BITS   = calc_idx_bits(MEM_LINES);
    localparam int unsigned CNT_W      = $clog2(MEM_LATENCY + 1);

    typedef logic [CACHE_LINE_SIZE-1:0] line_t;

    state_e              state_q, state_d;
    port_e               port_q, port_d;
    logic                wr_q, wr_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    line_t               wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    line_t               i_rdata_q, i_rdata_d;
    line_t               d_rdata_q, d_rdata_d;
    logic                req;
    logic                arr_we;
    line_t               arr_rdata;

    logic [IDX_BITS-1:0] i_idx, d_idx;
    logic                unused_addr;

    // Offset bits and bits above the index are ignored, so addresses wrap.
    assign i_idx = in_i_addr[OFF_BITS +: IDX_BITS];
    assign d_idx = in_d_addr[OFF_BITS +: IDX_BITS];
    assign unused_addr = ^{in_i_addr[31:OFF_BITS+IDX_BITS], in_i_addr[OFF_BITS-1:0],
                           in_d_addr[31:OFF_BITS+IDX_BITS], in_d_addr[OFF_BITS-1:0]};

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        req       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_d_read_en || in_d_write_en) begin
                    req     = 1'b1;
                    port_d  = PortD;
                    wr_d    = in_d_write_en;   // write wins if both are raised
                    idx_d   = d_idx;
                    wdata_d = in_d_write_data;
                end else if (in_i_read_en) begin
                    req    = 1'b1;
                    port_d = PortI;
                    wr_d   = 1'b0;
                    idx_d  = i_idx;
                end
                if (req) begin
                    if (MEM_LATENCY == 1) begin
                        state_d = StRespond;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                state_d = StCooldown;
                if (!wr_q) begin
                    if (port_q == PortD) begin
                        d_rdata_d = arr_rdata;
                    end else begin
                        i_rdata_d = arr_rdata;
                    end
                end
            end
            StCooldown: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            port_q    <= PortI;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            wr_q      <= wr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Addressing the array with idx_d lets the registered read already hold the
    // requested line when RESPOND is entered, even with a latency of one.
    assign arr_we = (state_q == StRespond) && wr_q && !reset;

    mem_line_array #(
        .LINE_W (CACHE_LINE_SIZE),
        .DEPTH  (MEM_LINES),
        .IDX_W  (IDX_BITS)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .idx_i   (idx_d),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign out_i_ready = (state_q == StRespond) && (port_q == PortI);
    assign out_d_ready = (state_q == StRespond) && (port_q == PortD);

    // During a read response the fresh array line is presented; otherwise the held copy.
    assign out_i_read_data = (out_i_ready && !wr_q) ? arr_rdata : i_rdata_q;
    assign out_d_read_data = (out_d_ready && !wr_q) ? arr_rdata : d_rdata_q;

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

    localparam int unsigned LW  = 128;
    localparam int unsigned LAT = 5;
    typedef logic [LW-1:0] line_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_en;
    logic [31:0] i_addr;
    line_t       i_rdata;
    logic        i_rdy;
    logic        d_ren, d_wen;
    logic [31:0] d_addr;
    line_t       d_wdata, d_rdata;
    logic        d_rdy;

    // Second instance with a latency of one.
    logic        f_i_en;
    logic [31:0] f_i_addr;
    line_t       f_i_rdata;
    logic        f_i_rdy;
    logic        f_d_ren, f_d_wen;
    logic [31:0] f_d_addr;
    line_t       f_d_wdata, f_d_rdata;
    logic        f_d_rdy;

    main_memory #(
        .CACHE_LINE_SIZE (LW),
        .MEM_LINES       (1024),
        .MEM_LATENCY     (LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_i_read_en    (i_en),
        .in_i_addr       (i_addr),
        .out_i_read_data (i_rdata),
        .out_i_ready     (i_rdy),
        .in_d_read_en    (d_ren),
        .in_d_write_en   (d_wen),
        .in_d_addr       (d_addr),
        .in_d_write_data (d_wdata),
        .out_d_read_data (d_rdata),
        .out_d_ready     (d_rdy)
    );

    main_memory #(
        .CACHE_LINE_SIZE (LW),
        .MEM_LINES       (1024),
        .MEM_LATENCY     (1)
    ) dut_fast (
        .clk             (clk),
        .reset           (reset),
        .in_i_read_en    (f_i_en),
        .in_i_addr       (f_i_addr),
        .out_i_read_data (f_i_rdata),
        .out_i_ready     (f_i_rdy),
        .in_d_read_en    (f_d_ren),
        .in_d_write_en   (f_d_wen),
        .in_d_addr       (f_d_addr),
        .in_d_write_data (f_d_wdata),
        .out_d_read_data (f_d_rdata),
        .out_d_ready     (f_d_rdy)
    );

    int    checks = 0;
    int    errors = 0;
    line_t model [int];
    line_t exp_i_last, exp_d_last;

    // 16-byte lines, 1024 lines: index is the line number modulo the line count.
    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd16) % 32'd1024);
    endfunction

    // One transaction on the latency-5 instance: start in an IDLE cycle, check the
    // latency, data, held data on the idle paths and the single-cycle pulse.
    task automatic do_txn(input bit is_d, input bit is_wr, input logic [31:0] addr,
                          input line_t wdata, input string name);
        int    n;
        bit    got;
        bit    other_hi;
        line_t exp;
        @(posedge clk); #1;
        if (is_d) begin
            d_ren = !is_wr; d_wen = is_wr; d_addr = addr; d_wdata = wdata;
        end else begin
            i_en = 1'b1; i_addr = addr;
        end
        n = 0; got = 0; other_hi = 0;
        while (!got && n <= int'(LAT) + 3) begin
            @(negedge clk);
            if ((is_d ? i_rdy : d_rdy) !== 1'b0) other_hi = 1;
            if ((is_d ? d_rdy : i_rdy) === 1'b1) got = 1;
            else n++;
        end
        checks++;
        if (!got || n != int'(LAT)) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d) want %0d", name, n, got, LAT);
        end
        checks++;
        if (other_hi) begin
            errors++;
            $display("FAIL %s other_ready: got pulse want 0", name);
        end
        if (got) begin
            if (is_wr) begin
                checks++;
                if (d_rdata !== exp_d_last) begin
                    errors++;
                    $display("FAIL %s d_hold: got %h want %h", name, d_rdata, exp_d_last);
                end
                model[idx_of(addr)] = wdata;
            end else begin
                exp = model[idx_of(addr)];
                checks++;
                if ((is_d ? d_rdata : i_rdata) !== exp) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h", name,
                             is_d ? d_rdata : i_rdata, exp);
                end
                if (is_d) exp_d_last = exp; else exp_i_last = exp;
            end
            checks++;
            if ((is_d ? i_rdata : d_rdata) !== (is_d ? exp_i_last : exp_d_last)) begin
                errors++;
                $display("FAIL %s idle_port_hold: got %h want %h", name,
                         is_d ? i_rdata : d_rdata, is_d ? exp_i_last : exp_d_last);
            end
        end
        @(posedge clk); #1;
        d_ren = 0; d_wen = 0; i_en = 0;
        @(negedge clk);
        checks++;
        if (i_rdy !== 1'b0 || d_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: got i=%b d=%b want 0 0", name, i_rdy, d_rdy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (i_rdy !== 1'b0 || d_rdy !== 1'b0 || i_rdata !== '0 || d_rdata !== '0 ||
            f_i_rdy !== 1'b0 || f_d_rdy !== 1'b0 || f_i_rdata !== '0 || f_d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready %b%b%b%b data nonzero=%b want all 0",
                     i_rdy, d_rdy, f_i_rdy, f_d_rdy,
                     |{i_rdata, d_rdata, f_i_rdata, f_d_rdata});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_i_last = '0;
        exp_d_last = '0;
    endtask

    task automatic test_i_read();
        line_t a5;
        a5 = {16{8'hA5}};
        do_txn(1, 1, 32'h30, a5, "preload_line3");
        do_txn(0, 0, 32'h30, '0, "i_read_line3");
    endtask

    task automatic test_write_read();
        line_t v;
        v = {4{32'hDEADBEEF}};
        do_txn(1, 1, 32'h40, v, "d_write_40");
        do_txn(1, 0, 32'h4C, '0, "d_read_4c");
    endtask

    task automatic test_simultaneous();
        int d_at, i_at, d_cnt;
        @(posedge clk); #1;
        i_en = 1; i_addr = 32'h30; d_ren = 1; d_addr = 32'h44;
        d_at = -1; i_at = -1; d_cnt = 0;
        for (int c = 0; c < 30 && i_at < 0; c++) begin
            @(negedge clk);
            if (d_rdy === 1'b1) begin
                d_cnt++;
                d_at = c;
                checks++;
                if (d_rdata !== model[idx_of(32'h44)]) begin
                    errors++;
                    $display("FAIL simul_d_data: got %h want %h", d_rdata, model[idx_of(32'h44)]);
                end
                exp_d_last = model[idx_of(32'h44)];
            end
            if (i_rdy === 1'b1) begin
                i_at = c;
                checks++;
                if (i_rdata !== model[idx_of(32'h30)]) begin
                    errors++;
                    $display("FAIL simul_i_data: got %h want %h", i_rdata, model[idx_of(32'h30)]);
                end
                exp_i_last = model[idx_of(32'h30)];
            end
            @(posedge clk); #1;
            if (d_at >= 0) d_ren = 0;
            if (i_at >= 0) i_en = 0;
        end
        i_en = 0; d_ren = 0;
        checks++;
        if (d_at != int'(LAT) || d_cnt != 1) begin
            errors++;
            $display("FAIL simul_d_time: got cycle %0d pulses %0d want %0d 1", d_at, d_cnt, LAT);
        end
        checks++;
        if (i_at != 2 * int'(LAT) + 2) begin
            errors++;
            $display("FAIL simul_i_time: got cycle %0d want %0d", i_at, 2 * LAT + 2);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_held_enable();
        int at, pulses;
        @(posedge clk); #1;
        i_en = 1; i_addr = 32'h3C;
        at = -1; pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (i_rdy === 1'b1) begin
                pulses++;
                at = c;
            end
            @(posedge clk); #1;
            if (at >= 0 && c >= at + 1) i_en = 0;
        end
        i_en = 0;
        checks++;
        if (pulses != 1 || at != int'(LAT)) begin
            errors++;
            $display("FAIL held_enable: got %0d pulses at %0d want 1 at %0d", pulses, at, LAT);
        end
        exp_i_last = model[idx_of(32'h3C)];
        checks++;
        if (i_rdata !== exp_i_last) begin
            errors++;
            $display("FAIL held_enable_data: got %h want %h", i_rdata, exp_i_last);
        end
    endtask

    task automatic test_reset_mid();
        line_t old_v, new_v;
        int    pulses;
        old_v = {4{32'h0BAD_F00D}};
        new_v = {4{32'h1234_5678}};
        do_txn(1, 1, 32'h50, old_v, "mid_preload");
        do_txn(1, 0, 32'h50, '0, "mid_preload_read");
        pulses = 0;
        @(posedge clk); #1;
        d_wen = 1; d_addr = 32'h50; d_wdata = new_v;
        @(negedge clk); if (d_rdy === 1'b1 || i_rdy === 1'b1) pulses++;
        @(posedge clk); #1;
        @(negedge clk); if (d_rdy === 1'b1 || i_rdy === 1'b1) pulses++;
        @(posedge clk); #1;
        reset = 1; d_wen = 0;
        @(negedge clk); if (d_rdy === 1'b1 || i_rdy === 1'b1) pulses++;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        checks++;
        if (i_rdy !== 1'b0 || d_rdy !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdy %b%b d %h i %h want all 0",
                     i_rdy, d_rdy, d_rdata, i_rdata);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (d_rdy === 1'b1 || i_rdy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset_no_ready: got %0d pulses want 0", pulses);
        end
        exp_i_last = '0;
        exp_d_last = '0;
        do_txn(1, 0, 32'h50, '0, "mid_reset_old_line");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          idx, op;
        line_t       v;
        for (int k = 0; k < 30; k++) begin
            idx = int'($urandom_range(0, 15));
            a = ($urandom & 32'hFFFF_C00F) | (32'(idx) << 4);
            op = int'($urandom_range(0, 2));
            v = {$urandom, $urandom, $urandom, $urandom};
            if (!model.exists(idx_of(a)) || op == 0) do_txn(1, 1, a, v, "rand_write");
            else if (op == 1) do_txn(1, 0, a, '0, "rand_d_read");
            else do_txn(0, 0, a, '0, "rand_i_read");
        end
    endtask

    task automatic test_wrap_lat1();
        line_t v;
        v = {4{32'hC0FF_EE01}};
        @(posedge clk); #1;
        f_d_wen = 1; f_d_addr = 32'h30; f_d_wdata = v;
        @(negedge clk);
        checks++;
        if (f_d_rdy !== 1'b0) begin
            errors++; $display("FAIL lat1_write_early: got %b want 0", f_d_rdy);
        end
        @(negedge clk);
        checks++;
        if (f_d_rdy !== 1'b1) begin
            errors++; $display("FAIL lat1_write_ready: got %b want 1", f_d_rdy);
        end
        @(posedge clk); #1; f_d_wen = 0;
        @(posedge clk); #1;
        f_d_ren = 1; f_d_addr = 32'h4030;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (f_d_rdy !== 1'b1 || f_d_rdata !== v) begin
            errors++;
            $display("FAIL lat1_wrap_d_read: got rdy %b data %h want 1 %h", f_d_rdy, f_d_rdata, v);
        end
        @(posedge clk); #1; f_d_ren = 0;
        @(posedge clk); #1;
        f_i_en = 1; f_i_addr = 32'h8038;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (f_i_rdy !== 1'b1 || f_i_rdata !== v) begin
            errors++;
            $display("FAIL lat1_wrap_i_read: got rdy %b data %h want 1 %h", f_i_rdy, f_i_rdata, v);
        end
        @(posedge clk); #1; f_i_en = 0;
        @(negedge clk);
        checks++;
        if (f_i_rdy !== 1'b0 || f_i_rdata !== v) begin
            errors++;
            $display("FAIL lat1_hold: got rdy %b data %h want 0 %h", f_i_rdy, f_i_rdata, v);
        end
    endtask

    initial begin
        reset = 1; i_en = 0; i_addr = '0; d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
        f_i_en = 0; f_i_addr = '0; f_d_ren = 0; f_d_wen = 0; f_d_addr = '0; f_d_wdata = '0;
        exp_i_last = '0; exp_d_last = '0;
        test_reset();
        test_i_read();
        test_write_read();
        test_simultaneous();
        test_held_enable();
        test_reset_mid();
        test_random();
        test_wrap_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/main_memory.md
# main_memory

Line-granular backing memory that answers cache-line refill and write-back requests from the instruction cache and the data cache. It sits below both caches and drives their `in_mem_read_data` / `in_mem_ready` inputs with a configurable fixed access latency. One request is serviced at a time. When both caches request in the same cycle, the data port wins.

## Interface
- `CACHE_LINE_SIZE`, 128: line width in bits; a multiple of 32.
- `MEM_LINES`, 1024: number of lines stored; a power of two.
- `MEM_LATENCY`, 5: cycles from request acceptance to `ready`; must be ≥1.

Clock and reset are `clk` and `reset`: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_i_read_en`  in  1  instruction-cache line read request
- `in_i_addr`  in  32  instruction-cache byte address
- `out_i_read_data`  out  CACHE_LINE_SIZE  line returned to the instruction cache
- `out_i_ready`  out  1  one-cycle completion pulse, instruction port
- `in_d_read_en`  in  1  data-cache line read (refill) request
- `in_d_write_en`  in  1  data-cache line write (write-back) request
- `in_d_addr`  in  32  data-cache byte address
- `in_d_write_data`  in  CACHE_LINE_SIZE  write-back line
- `out_d_read_data`  out  CACHE_LINE_SIZE  line returned to the data cache
- `out_d_ready`  out  1  one-cycle completion pulse, data port

## Operation
- **Addressing**
  - Line index = `addr[OFF +: IDX]`, where OFF = log2(CACHE_LINE_SIZE/8) and IDX = log2(MEM_LINES).
  - The offset bits and all bits above the index are ignored, so the index wraps.
- **Request handshake**
  - A requester holds its enable, address and write data stable until its `ready` pulse.
  - It deasserts its enable in the cycle after the pulse.
- **State machine** (4 states):
  - **IDLE:** sample requests.
    - If either data enable is high, latch the data request (port=D, op, index, write data).
    - Otherwise, if `in_i_read_en` is high, latch the instruction request (port=I).
    - Then go to BUSY, loading the counter with MEM_LATENCY−1. If MEM_LATENCY=1, go straight to RESPOND.
  - **BUSY:** decrement the counter each cycle; go to RESPOND when the counter is 1.
  - **RESPOND:** assert the selected port's `ready` for exactly one cycle.
    - On a read, present array[index] on that port's `read_data`.
    - On a write, commit the latched line to array[index] on this edge.
    - Go to COOLDOWN.
  - **COOLDOWN:** one cycle with no sampling, so a still-held enable is not re-serviced. Go to IDLE.
- **Data-port operation select**
  - `in_d_write_en` together with `in_d_read_en` is illegal; the responder performs the write only.
  - A write response drives `out_d_ready` high; `out_d_read_data` holds its previous value.
- **Unselected port:** keeps its enable high and is served after the current transaction. The instruction port can wait behind back-to-back data requests; this is accepted because the pipeline is stalled during data-cache misses.
- **Read-data outputs:** registered, and held until that port's next read response.

## Timing
- **Latency**
  - Request first visible in IDLE at cycle T → `ready` high in cycle T+MEM_LATENCY.
  - The next request is sampled no earlier than T+MEM_LATENCY+2.
  - Minimum throughput: one transaction per MEM_LATENCY+2 cycles.
- **Read data:** valid in the same cycle as `ready`.
- **Write visibility:** a read of the same index accepted after a write's RESPOND returns the new line.
- **Reset values**
  - state = IDLE, counter = 0.
  - `out_i_ready` = `out_d_ready` = 0.
  - `out_i_read_data` = `out_d_read_data` = 0.
  - Array contents are not cleared; they are preserved across reset.
- **Reset mid-transaction:** the in-flight request is dropped, no `ready` is issued, and a pending write is not committed.
- **Counter width:** $clog2(MEM_LATENCY+1).

## Structure
- **Package `mem_pkg`:**
  - state enum (IDLE, BUSY, RESPOND, COOLDOWN);
  - port-select enum (PORT_I, PORT_D);
  - localparams LINE_BYTES, OFF_BITS, IDX_BITS derived from the module parameters via functions.
- **Sub-module `mem_line_array`:**
  - MEM_LINES × CACHE_LINE_SIZE storage with one synchronous read/write port;
  - write enable and index are driven from RESPOND;
  - read data is registered.
- The FSM, arbiter and latency counter stay in `main_memory`.

## Test plan
- **I-read, MEM_LATENCY=5:** preload line 3 = 128'hA5…; `in_i_read_en`=1, `in_i_addr`=32'h30 at cycle 10 → `out_i_ready` high only in cycle 15 with that data; `out_d_ready` stays 0.
- **Write then read:** D-write 128'hDEADBEEF_… to addr 32'h40; after its `ready`, D-read 32'h4C (same line, offset ignored) → returns 128'hDEADBEEF_….
- **Simultaneous requests:** I- and D-read both raised at cycle T → D served, `out_d_ready` at T+5; I accepted at T+7, `out_i_ready` at T+12.
- **Held enable across COOLDOWN:** requester keeps `in_i_read_en` high 1 cycle after `ready` → exactly one `ready` pulse.
- **Reset mid-transaction:** reset at cycle T+2 of a D-write → no `ready`; target line keeps its old contents; all outputs 0 the cycle after reset.
- **Wrap and MEM_LATENCY=1:** `in_d_addr` = 32'h4030 with MEM_LINES=1024 → same line as 32'h30; with MEM_LATENCY=1, `ready` arrives at T+1.
